// File: rtl/quad_enc_gen.sv
//------------------------------------------------------------------------------
// quad_enc_gen
//
// Quadrature encoder generator. Turns a signed detent command into ck/dt
// quadrature waveforms for a rotary decoder, for loopback self-test or to
// emulate front-panel input. A receiver that counts each ck edge as +1 when
// ck==dt after the edge (CW) and -1 otherwise (CCW) reads back the command.
//
// Ports
//   aclk       in   1  clock, all logic on the rising edge
//   aresetn    in   1  asynchronous active-low reset
//   cmd_valid  in   1  command strobe
//   cmd_ready  out  1  high only while idle; accept = cmd_valid && cmd_ready
//   cmd_steps  in   8  signed detents: >0 CW, <0 CCW, -128..127
//   abort      in   1  level; stop after the detent in progress
//   busy       out  1  high while a command executes
//   remaining  out  8  unsigned detents left, including the one in progress
//   done       out  1  one-cycle pulse at command completion
//   ck         out  1  quadrature clock line
//   dt         out  1  quadrature data line
//
// Parameters
//   PHASE_CYCLES   aclk cycles per quadrature phase (>= 2); one detent takes
//                  2*PHASE_CYCLES cycles
//   BOUNCE_CYCLES  bounce window after each line edge (bounce build only)
//
// Optional feature
//   QUAD_GEN_BOUNCE_EN  when defined, every ck/dt edge is followed by a
//                       BOUNCE_CYCLES-cycle window in which the line shows the
//                       new value on even cycles and the old value on odd
//                       cycles (cycle 0 = the edge). Nominal timing and state
//                       sequencing are identical in both builds.
//------------------------------------------------------------------------------
module quad_enc_gen #(
   parameter int PHASE_CYCLES  = 32000,
   parameter int BOUNCE_CYCLES = 8
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_steps,
   input  logic       abort,
   output logic       busy,
   output logic [7:0] remaining,
   output logic       done,
   output logic       ck,
   output logic       dt
);

   localparam int CW = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;

   // HOLD_DT lasts PHASE_CYCLES-1 cycles because the SET_DT cycle already
   // counts towards the first phase; HOLD_CK lasts a full PHASE_CYCLES.
   localparam logic [CW-1:0] C_LOAD_DT = CW'(PHASE_CYCLES - 2);
   localparam logic [CW-1:0] C_LOAD_CK = CW'(PHASE_CYCLES - 1);

   // Elaboration-time parameter sanity checks.
   if (PHASE_CYCLES < 2) begin : g_bad_phase
      $error("quad_enc_gen: PHASE_CYCLES must be >= 2");
   end
   if (BOUNCE_CYCLES < 0) begin : g_bad_bounce_neg
      $error("quad_enc_gen: BOUNCE_CYCLES must not be negative");
   end
`ifdef QUAD_GEN_BOUNCE_EN
   if (BOUNCE_CYCLES >= PHASE_CYCLES) begin : g_bad_bounce_len
      $error("quad_enc_gen: BOUNCE_CYCLES must be < PHASE_CYCLES");
   end
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SET_DT  = 3'd1,
      S_HOLD_DT = 3'd2,
      S_HOLD_CK = 3'd3,
      S_FINISH  = 3'd4
   } state_t;

   state_t          r_state,  w_state_next;
   logic [CW-1:0]   r_cnt,    w_cnt_next;
   logic [7:0]      r_rem,    w_rem_next;
   logic            r_dir_cw, w_dir_cw_next;
   logic            r_ck,     w_ck_next;
   logic            r_dt,     w_dt_next;

   logic [7:0]      w_steps_mag;
   logic [7:0]      w_rem_dec;

   // Two's-complement magnitude; -128 maps to 8'h80 = 128 unsigned.
   assign w_steps_mag = cmd_steps[7] ? (~cmd_steps + 8'd1) : cmd_steps;
   assign w_rem_dec   = r_rem - 8'd1;

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rem    <= 8'd0;
         r_dir_cw <= 1'b1;
         r_ck     <= 1'b0;
         r_dt     <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_rem    <= w_rem_next;
         r_dir_cw <= w_dir_cw_next;
         r_ck     <= w_ck_next;
         r_dt     <= w_dt_next;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic. The line registers are written on the transition INTO
   // a state, so the dt update is visible during the SET_DT cycle itself and
   // the ck toggle during the first HOLD_CK cycle. That places the ck edge
   // exactly PHASE_CYCLES after the dt edge and keeps the detent period at
   // 2*PHASE_CYCLES. ck and dt are never written on the same transition, so
   // only one line moves per edge.
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_rem_next    = r_rem;
      w_dir_cw_next = r_dir_cw;
      w_ck_next     = r_ck;
      w_dt_next     = r_dt;

      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_dir_cw_next = ~cmd_steps[7];
               w_rem_next    = w_steps_mag;
               if (cmd_steps == 8'd0) begin
                  w_state_next = S_FINISH;
               end else begin
                  w_state_next = S_SET_DT;
                  // CW: dt becomes ~ck; CCW: dt follows ck.
                  w_dt_next    = cmd_steps[7] ? r_ck : ~r_ck;
               end
            end
         end

         S_SET_DT: begin
            w_state_next = S_HOLD_DT;
            w_cnt_next   = C_LOAD_DT;
         end

         S_HOLD_DT: begin
            if (r_cnt == '0) begin
               w_state_next = S_HOLD_CK;
               w_ck_next    = ~r_ck;
               w_cnt_next   = C_LOAD_CK;
            end else begin
               w_cnt_next   = r_cnt - 1'b1;
            end
         end

         S_HOLD_CK: begin
            if (r_cnt == '0) begin
               w_rem_next = w_rem_dec;
               // abort is only looked at here, so a started detent always
               // completes and the receiver never sees a half step.
               if ((w_rem_dec == 8'd0) || abort) begin
                  w_state_next = S_FINISH;
               end else begin
                  w_state_next = S_SET_DT;
                  w_dt_next    = r_dir_cw ? ~r_ck : r_ck;
               end
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end

         S_FINISH: begin
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_FINISH);
   assign remaining = r_rem;

   //---------------------------------------------------------------------------
   // Line drivers
   //---------------------------------------------------------------------------
   logic [1:0] w_line_nom;
   logic [1:0] w_line_out;

   assign w_line_nom = {r_ck, r_dt};

`ifdef QUAD_GEN_BOUNCE_EN
   localparam int BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;

   logic [1:0] w_line_nom_next;
   assign w_line_nom_next = {w_ck_next, w_dt_next};

   // One bounce tracker per line. r_idx is the cycle index inside the window
   // (0 = edge cycle); the nominal value is inverted on odd indices, which for
   // a single-bit line is exactly "show the old value".
   for (genvar gi = 0; gi < 2; gi++) begin : g_bounce
      logic          r_act;
      logic [BW-1:0] r_idx;

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            r_act <= 1'b0;
            r_idx <= '0;
         end else if (w_line_nom_next[gi] != w_line_nom[gi]) begin
            r_act <= (BOUNCE_CYCLES > 0);
            r_idx <= '0;
         end else if (r_act) begin
            if (r_idx == BW'(BOUNCE_CYCLES - 1)) begin
               r_act <= 1'b0;
            end
            r_idx <= r_idx + 1'b1;
         end
      end

      assign w_line_out[gi] = w_line_nom[gi] ^ (r_act & r_idx[0]);
   end
`else
   assign w_line_out = w_line_nom;
`endif

   assign ck = w_line_out[1];
   assign dt = w_line_out[0];

endmodule

// File: tb/tb_quad_enc_gen.sv
//------------------------------------------------------------------------------
// tb_quad_enc_gen
//
// Directed bench for quad_enc_gen with PHASE_CYCLES=4, BOUNCE_CYCLES=2.
// The stimulus process pushes hand-computed line edges and done events into
// queues; a monitor running on the falling edge pops and compares them as the
// DUT produces them, and also keeps a receiver-style detent count.
//
// Cycle bookkeeping: cyc increments on every rising edge. A command accepted
// on the rising edge that makes cyc == t0 shows its first effect in the
// interval where cyc == t0, so an event the block describes at "T0+k" is
// expected at cyc == t0+k-1.
//------------------------------------------------------------------------------
module tb_quad_enc_gen;

   localparam int P = 4;
   localparam int B = 2;

   logic       aclk;
   logic       aresetn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_steps;
   logic       abort;
   logic       busy;
   logic [7:0] remaining;
   logic       done;
   logic       ck;
   logic       dt;

   quad_enc_gen #(
      .PHASE_CYCLES  (P),
      .BOUNCE_CYCLES (B)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_steps (cmd_steps),
      .abort     (abort),
      .busy      (busy),
      .remaining (remaining),
      .done      (done),
      .ck        (ck),
      .dt        (dt)
   );

   typedef struct {
      int         cyc;
      logic [1:0] line;   // {ck, dt}
   } edge_t;

   typedef struct {
      int         cyc;
      logic [7:0] rem;
      logic [1:0] line;
   } done_t;

   edge_t      edge_q[$];
   done_t      done_q[$];
   int         total    = 0;
   int         bad      = 0;
   int         cyc      = 0;
   int         rx_count = 0;
   logic [1:0] prev_line = 2'b00;

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   always @(posedge aclk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_edge(input int c, input logic [1:0] line);
      edge_t e;
      e.cyc  = c;
      e.line = line;
`ifndef QUAD_GEN_BOUNCE_EN
      edge_q.push_back(e);
`endif
   endtask

   task automatic exp_done(input int c, input logic [7:0] rem, input logic [1:0] line);
      done_t d;
      d.cyc  = c;
      d.rem  = rem;
      d.line = line;
      done_q.push_back(d);
   endtask

   //---------------------------------------------------------------------------
   // Monitor
   //---------------------------------------------------------------------------
   always @(negedge aclk) begin
      edge_t e;
      done_t d;
      if (!aresetn) begin
         prev_line = {ck, dt};
      end else begin
`ifndef QUAD_GEN_BOUNCE_EN
         if ({ck, dt} !== prev_line) begin
            if (ck !== prev_line[1]) rx_count = rx_count + ((ck == dt) ? 1 : -1);
            if (edge_q.size() == 0) begin
               total = total + 1;
               bad   = bad + 1;
               $display("FAIL unexpected_edge: got ck=%0b dt=%0b want no change (cyc %0d)", ck, dt, cyc);
            end else begin
               e = edge_q.pop_front();
               chk("edge_line", {30'd0, ck, dt}, {30'd0, e.line});
               chk("edge_cyc", cyc, e.cyc);
            end
         end
`endif
         prev_line = {ck, dt};
         if (done === 1'b1) begin
            if (done_q.size() == 0) begin
               total = total + 1;
               bad   = bad + 1;
               $display("FAIL unexpected_done: got done=1 want 0 (cyc %0d)", cyc);
            end else begin
               d = done_q.pop_front();
               chk("done_cyc", cyc, d.cyc);
               chk("done_remaining", {24'd0, remaining}, {24'd0, d.rem});
               chk("done_line", {30'd0, ck, dt}, {30'd0, d.line});
               $display("txn done: cyc=%0d remaining=%0d ck=%0b dt=%0b", cyc, remaining, ck, dt);
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus helpers
   //---------------------------------------------------------------------------
   task automatic send(input logic [7:0] s, output int t0);
      @(negedge aclk);
      chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
      rx_count  = 0;
      cmd_valid = 1'b1;
      cmd_steps = s;
      @(posedge aclk);
      #1;
      cmd_valid = 1'b0;
      cmd_steps = 8'd0;
      t0 = cyc;
      $display("txn issue: steps=%0d t0=%0d", $signed(s), t0);
   endtask

   task automatic at_cyc(input int c);
      @(negedge aclk);
      while (cyc < c) @(negedge aclk);
   endtask

   task automatic wait_ready(input int exp_cyc, input string name);
      int i;
      i = 0;
      @(negedge aclk);
      while (!cmd_ready && i < 600) begin
         @(negedge aclk);
         i++;
      end
      if (!cmd_ready) begin
         total = total + 1;
         bad   = bad + 1;
         $display("FAIL %s_timeout: got cmd_ready=0 want 1 within 600 cycles", name);
      end else begin
         chk(name, cyc, exp_cyc);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ck"},        {31'd0, ck},        32'd0);
      chk({tag, "_dt"},        {31'd0, dt},        32'd0);
      chk({tag, "_ready"},     {31'd0, cmd_ready}, 32'd1);
      chk({tag, "_busy"},      {31'd0, busy},      32'd0);
      chk({tag, "_done"},      {31'd0, done},      32'd0);
      chk({tag, "_remaining"}, {24'd0, remaining}, 32'd0);
   endtask

   //---------------------------------------------------------------------------
   // Directed sequence
   //---------------------------------------------------------------------------
   initial begin
      int t0;
      aresetn   = 1'b1;
      cmd_valid = 1'b0;
      cmd_steps = 8'd0;
      abort     = 1'b0;
      #2 aresetn = 1'b0;
      #1 chk_reset_vals("in_reset");
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         chk_reset_vals("idle");
      end

      // +3 from (0,0); a command offered while busy must be ignored.
      send(8'd3, t0);
      exp_edge(t0 + 0,  2'b01);
      exp_edge(t0 + 4,  2'b11);
      exp_edge(t0 + 8,  2'b10);
      exp_edge(t0 + 12, 2'b00);
      exp_edge(t0 + 16, 2'b01);
      exp_edge(t0 + 20, 2'b11);
      exp_done(t0 + 24, 8'd0, 2'b11);
      chk("p3_remaining_start", {24'd0, remaining}, 32'd3);
      chk("p3_busy", {31'd0, busy}, 32'd1);
      chk("p3_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge aclk);
      cmd_valid = 1'b1;
      cmd_steps = 8'hFF;
      repeat (2) @(negedge aclk);
      cmd_valid = 1'b0;
      cmd_steps = 8'd0;
      at_cyc(t0 + 8);
      chk("p3_remaining_mid", {24'd0, remaining}, 32'd2);
      wait_ready(t0 + 25, "p3_ready_after_done");
`ifndef QUAD_GEN_BOUNCE_EN
      chk("p3_rx_count", rx_count, 32'd3);
`endif

      // Zero command: done immediately, lines untouched at (1,1).
      send(8'd0, t0);
      exp_done(t0, 8'd0, 2'b11);
      wait_ready(t0 + 1, "zero_ready_after_done");

      // -2 from (1,1): first CCW SET_DT leaves dt unchanged.
      send(8'hFE, t0);
      exp_edge(t0 + 4,  2'b01);
      exp_edge(t0 + 8,  2'b00);
      exp_edge(t0 + 12, 2'b10);
      exp_done(t0 + 16, 8'd0, 2'b10);
      chk("m2_remaining_start", {24'd0, remaining}, 32'd2);
      wait_ready(t0 + 17, "m2_ready_after_done");
`ifndef QUAD_GEN_BOUNCE_EN
      chk("m2_rx_count", rx_count, -32'sd2);
`endif

      // +5 from (1,0) with abort raised during detent 2: stops after it.
      send(8'd5, t0);
      exp_edge(t0 + 4,  2'b00);
      exp_edge(t0 + 8,  2'b01);
      exp_edge(t0 + 12, 2'b11);
      exp_done(t0 + 16, 8'd3, 2'b11);
      at_cyc(t0 + 9);
      abort = 1'b1;
      wait_ready(t0 + 17, "abort_ready_after_done");
      chk("abort_remaining_held", {24'd0, remaining}, 32'd3);
`ifndef QUAD_GEN_BOUNCE_EN
      chk("abort_rx_count", rx_count, 32'd2);
`endif
      // abort held in IDLE must not start anything.
      repeat (3) @(negedge aclk);
      chk("abort_idle_busy", {31'd0, busy}, 32'd0);
      chk("abort_idle_ready", {31'd0, cmd_ready}, 32'd1);
      abort = 1'b0;

      // -128 then asynchronous reset in HOLD_DT of the first detent.
      send(8'h80, t0);
      chk("m128_remaining_start", {24'd0, remaining}, 32'd128);
      at_cyc(t0 + 2);
      chk("m128_line_before_reset", {30'd0, ck, dt}, 32'd3);
      chk("m128_busy_before_reset", {31'd0, busy}, 32'd1);
      #2 aresetn = 1'b0;
      #1 chk_reset_vals("async_reset");
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;

      // +1 after reset runs from (0,0).
      send(8'd1, t0);
      exp_edge(t0 + 0, 2'b01);
      exp_edge(t0 + 4, 2'b11);
      exp_done(t0 + 8, 8'd0, 2'b11);
`ifdef QUAD_GEN_BOUNCE_EN
      at_cyc(t0);
      chk("bounce_dt_0", {31'd0, dt}, 32'd1);
      at_cyc(t0 + 1);
      chk("bounce_dt_1", {31'd0, dt}, 32'd0);
      at_cyc(t0 + 2);
      chk("bounce_dt_2", {31'd0, dt}, 32'd1);
      at_cyc(t0 + 4);
      chk("bounce_ck_0", {31'd0, ck}, 32'd1);
      at_cyc(t0 + 5);
      chk("bounce_ck_1", {31'd0, ck}, 32'd0);
      at_cyc(t0 + 6);
      chk("bounce_ck_2", {31'd0, ck}, 32'd1);
`endif
      wait_ready(t0 + 9, "p1_ready_after_done");
`ifndef QUAD_GEN_BOUNCE_EN
      chk("p1_rx_count", rx_count, 32'd1);
`endif

      repeat (2) @(negedge aclk);
      chk("edge_q_drained", edge_q.size(), 32'd0);
      chk("done_q_drained", done_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
